pe_controller: RTL
==================

// Module: pe_controller
// PURPOSE
//  Sequencer for one PE (filter buffer, 16:1 tap mux, MAC, 4-deep output shift register, counter4).
//  Loads the 16-byte kernel 4 bytes per beat, then runs 16-tap MAC passes, one per output pixel.
//  Shifts each result into the shift register and presents every group of 4 results to the OFM writer.
//  Sits between the top-level layer FSM (start/done) and the PE datapath enables.
// PARAMETERS
//  TAPS       16  kernel taps per output; sel width = 4
//  LOAD_BEATS 4   kernel load beats, 4 bytes each; en1 width = TAPS
//  GROUP      4   outputs per shift-register flush; must match counter4 modulus
//  NOUT_W     8   width of num_outputs
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       asynchronous active-high reset
//  start        in   1       1-cycle request; honoured in IDLE only
//  load_filter  in   1       sampled with start; 1 = reload kernel before computing
//  num_outputs  in   NOUT_W  sampled with start; multiple of GROUP
//  flt_valid    in   1       kernel beat present on PE bufferInput
//  flt_ready    out  1       controller accepts kernel beat
//  ifm_valid    in   1       activation byte present on PE mac2Input
//  ifm_ready    out  1       controller consumes activation byte this cycle
//  en1          out  TAPS    filter buffer byte write enables
//  sel          out  4       tap index to mux16to1
//  en2, rst2    out  1 each  MAC accumulate enable / synchronous clear
//  en3          out  1       shift register shift enable
//  en4, rst4    out  1 each  counter4 increment / clear
//  cout4        in   1       counter4 carry: high when count==GROUP-1 and en4
//  out_valid    out  1       shift register holds GROUP valid results
//  out_ready    in   1       OFM writer accepts the group
//  busy         out  1       high in every state except IDLE
//  done         out  1       1-cycle pulse at end of job
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; internal counters 0. Reset mid-job aborts without done.
//  States: IDLE, LOAD, CLEAR, RUN, STORE, FLUSH, FIN.
//  IDLE: on start, latch load_filter and num_outputs; pulse rst4 for 1 cycle.
//   Next state: LOAD if load_filter; else FIN if num_outputs==0; else CLEAR.
//   start while busy is ignored.
//  LOAD: flt_ready=1.
//   On flt_valid: en1 = 4'hF << (4*beat). Increment beat.
//   After beat LOAD_BEATS-1: next CLEAR (FIN if num_outputs==0). flt_valid low: hold, en1=0.
//  CLEAR: rst2=1 for 1 cycle; tap=0; next RUN.
//  RUN: sel=tap; ifm_ready=1; en2=ifm_valid.
//   On ifm_valid, tap++. After tap TAPS-1 is consumed: next STORE. ifm_valid low stalls; sel holds.
//  STORE: en3=1, en4=1 (macOut final after last en2 edge); out_cnt++.
//   cout4=1 -> FLUSH; else CLEAR.
//  FLUSH: out_valid=1; en3/en2 low; hold until out_ready.
//   On out_ready: FIN if out_cnt==num_outputs, else CLEAR.
//  FIN: done=1 for 1 cycle; next IDLE.
//  Timing, no stalls: 18 cycles per output (1 CLEAR + 16 RUN + 1 STORE); 72 cycles + FLUSH per group.
//  Kernel load: 4 cycles.
//  Outputs are registered (Moore) except en1, en2 and ifm_ready.
//   These are combinational from state and valid to avoid a 1-cycle bubble.
//  out_cnt width NOUT_W; non-multiple of GROUP is a caller error.
//   Remainder never flushes; bench asserts this is never driven.
// STRUCTURE
//  Shared package pe_ctrl_pkg: state enum, TAPS, LOAD_BEATS, GROUP constants.
//   Reused by the layer-level FSM and the bench.
//  One sub-module: pe_ctrl_counter (parameterised width, clr/inc, terminal flag).
//   Instantiated for beat, tap and out_cnt.
// TESTING
//  1. Reset mid-RUN (tap=7): all outputs 0 next edge; state IDLE; no done.
//  2. start, load_filter=1, num_outputs=4, valids tied high:
//   en1 = 000F, 00F0, 0F00, F000 on 4 consecutive cycles.
//   First out_valid at cycle 1+4+72; done 2 cycles after out_ready.
//  3. ifm_valid low for 3 cycles at tap 5: sel stays 5; en2=0; output latency grows by exactly 3.
//  4. num_outputs=8, out_ready held low 10 cycles on first group:
//   FLUSH holds; no en3 pulses. Second group starts the cycle after out_ready.
//  5. load_filter=0, num_outputs=0: rst4 pulse, done 2 cycles after start; en1 never asserted.
//  6. start pulsed during RUN: ignored; latched num_outputs unchanged; single done.

Source files
------------

// File: rtl/pe_ctrl_pkg.sv
// Shared constants and state encoding for the PE sequencer.
// Also imported by the layer-level FSM and the bench.
package pe_ctrl_pkg;

  localparam int TAPS       = 16;
  localparam int LOAD_BEATS = 4;
  localparam int GROUP      = 4;
  localparam int NOUT_W     = 8;
  localparam int SEL_W      = $clog2(TAPS);
  localparam int BEAT_W     = $clog2(LOAD_BEATS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_RUN,
    S_STORE,
    S_FLUSH,
    S_FIN
  } state_t;

endpackage

// File: rtl/pe_ctrl_counter.sv
// Clearable up-counter with a terminal flag against a runtime limit.
// Used for kernel beats, MAC taps and produced outputs.
module pe_ctrl_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] last,
  output logic [W-1:0] q,
  output logic         term
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= '0;
    else if (clr) q <= '0;
    else if (inc) q <= q + W'(1);
  end

  assign term = (q == last);

endmodule

// File: rtl/pe_controller.sv
// Sequencer for one PE: kernel load, 16-tap MAC passes,
// shift-register grouping and hand-off to the OFM writer.
module pe_controller
  import pe_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              load_filter,
  input  logic [NOUT_W-1:0] num_outputs,
  input  logic              flt_valid,
  output logic              flt_ready,
  input  logic              ifm_valid,
  output logic              ifm_ready,
  output logic [TAPS-1:0]   en1,
  output logic [SEL_W-1:0]  sel,
  output logic              en2,
  output logic              rst2,
  output logic              en3,
  output logic              en4,
  output logic              rst4,
  input  logic              cout4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(LOAD_BEATS - 1);
  localparam logic [SEL_W-1:0]  TAP_LAST  = SEL_W'(TAPS - 1);

  state_t state, state_n;

  logic [NOUT_W-1:0] nout_q;
  logic [NOUT_W-1:0] out_cnt;
  logic [BEAT_W-1:0] beat;
  logic beat_last, tap_last, out_last;
  logic accept;

  assign accept = (state == S_IDLE) && start;

  pe_ctrl_counter #(.W(BEAT_W)) u_beat (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .inc  ((state == S_LOAD) && flt_valid),
    .last (BEAT_LAST),
    .q    (beat),
    .term (beat_last)
  );

  pe_ctrl_counter #(.W(SEL_W)) u_tap (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == S_CLEAR),
    .inc  (en2),
    .last (TAP_LAST),
    .q    (sel),
    .term (tap_last)
  );

  pe_ctrl_counter #(.W(NOUT_W)) u_out (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .inc  (state == S_STORE),
    .last (nout_q),
    .q    (out_cnt),
    .term (out_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         nout_q <= '0;
    else if (accept) nout_q <= num_outputs;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (load_filter)           state_n = S_LOAD;
          else if (num_outputs == '0) state_n = S_FIN;
          else                       state_n = S_CLEAR;
        end
      end
      S_LOAD: begin
        if (flt_valid && beat_last)
          state_n = (nout_q == '0) ? S_FIN : S_CLEAR;
      end
      S_CLEAR: state_n = S_RUN;
      S_RUN: begin
        if (ifm_valid && tap_last) state_n = S_STORE;
      end
      S_STORE: state_n = cout4 ? S_FLUSH : S_CLEAR;
      S_FLUSH: begin
        if (out_ready) state_n = out_last ? S_FIN : S_CLEAR;
      end
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Valid-qualified strobes stay combinational so a beat is never lost
  assign ifm_ready = (state == S_RUN);
  assign en2       = ifm_ready && ifm_valid;

  always_comb begin
    en1 = '0;
    if ((state == S_LOAD) && flt_valid)
      en1 = {{(TAPS-4){1'b0}}, 4'hF} << {beat, 2'b00};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flt_ready <= 1'b0;
      rst2      <= 1'b0;
      en3       <= 1'b0;
      en4       <= 1'b0;
      rst4      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      flt_ready <= (state_n == S_LOAD);
      rst2      <= (state_n == S_CLEAR);
      en3       <= (state_n == S_STORE);
      en4       <= (state_n == S_STORE);
      rst4      <= accept;
      out_valid <= (state_n == S_FLUSH);
      busy      <= (state_n != S_IDLE);
      done      <= (state == S_FIN);
    end
  end

endmodule
